dsp_mac_sequencer: RTL and testbench

//  Initiator that drives one DSP48A1 slice, configured A0REG=0/A1REG=1/B0REG=0/B1REG=1/MREG=1/PREG=1/OPMODEREG=1.

---
 rtl/dsp_mac_sequencer_if.sv | 57 +++++
 rtl/dsp_mac_sequencer.sv | 162 ++++++++++++++++
 tb/tb_dsp_mac_sequencer.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dsp_mac_sequencer_if.sv
`timescale 1ns/1ps
// Bus bundle around dsp_mac_sequencer: command in, operand stream in,
// DSP48A1 slice drive/return, and the handshaked result out.
// Ports (master = sequencer side):
//   cmd_valid/cmd_ready/cmd_len  command handshake, cmd_len = products to sum
//   s_valid/s_ready/s_a/s_b      unsigned 18-bit operand pair stream
//   dsp_a/dsp_b/dsp_opmode/dsp_rst/dsp_p  slice operands, opmode, reset, P
//   res_valid/res_ready/res_data result handshake, 48-bit accumulated sum
//   busy                         sequencer is not idle
interface dsp_mac_sequencer_if #(
  parameter int LEN_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;

  logic             s_valid;
  logic             s_ready;
  logic [17:0]      s_a;
  logic [17:0]      s_b;

  logic [17:0]      dsp_a;
  logic [17:0]      dsp_b;
  logic [7:0]       dsp_opmode;
  logic             dsp_rst;
  logic [47:0]      dsp_p;

  logic             res_valid;
  logic             res_ready;
  logic [47:0]      res_data;

  logic             busy;

  // Sequencer side.
  modport master (
    input  cmd_valid, cmd_len,
    input  s_valid, s_a, s_b,
    input  dsp_p,
    input  res_ready,
    output cmd_ready, s_ready,
    output dsp_a, dsp_b, dsp_opmode, dsp_rst,
    output res_valid, res_data,
    output busy
  );

  // Environment side: command/operand source, slice, result sink.
  modport slave (
    output cmd_valid, cmd_len,
    output s_valid, s_a, s_b,
    output dsp_p,
    output res_ready,
    input  cmd_ready, s_ready,
    input  dsp_a, dsp_b, dsp_opmode, dsp_rst,
    input  res_valid, res_data,
    input  busy
  );
endinterface

// File: rtl/dsp_mac_sequencer.sv
`timescale 1ns/1ps
// Purpose: sequences one N-term multiply-accumulate through a DSP48A1 slice
//          (A1/B1/M/P/OPMODE registers on) and returns the 48-bit sum.
// Latency: res_valid rises PIPE_LAT+1 cycles after the last operand handshake;
//          one cycle after command accept when N=0.
// Backpressure: operand stalls become hold slots (P kept); a stalled result
//          holds DONE with res_data stable and blocks the next command.
//
// Ports:
//   clk   clock, all logic on posedge
//   RSTD  asynchronous active-high reset; also drives the slice reset
//   bus   dsp_mac_sequencer_if.master (command, operand, slice, result, busy)
module dsp_mac_sequencer #(
  parameter int LEN_W    = 8,
  parameter int OPM_SKEW = 1,  // opmode lag behind operand issue, >= 1
  parameter int PIPE_LAT = 3   // operand issue to P valid on dsp_p
) (
  input  logic                       clk,
  input  logic                       RSTD,
  dsp_mac_sequencer_if.master        bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int DRN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  // Opmode encodings, X in [1:0], Z in [3:2], upper nibble always zero.
  localparam logic [7:0] OPM_FIRST = 8'h01;  // X=M, Z=0   : restart P
  localparam logic [7:0] OPM_ACC   = 8'h09;  // X=M, Z=P   : accumulate
  localparam logic [7:0] OPM_HOLD  = 8'h08;  // X=0, Z=P   : keep P

  state_t                     state_q, state_d;
  logic [LEN_W-1:0]           len_q, len_d;
  logic [LEN_W-1:0]           cnt_q, cnt_d;
  logic [DRN_W-1:0]           drn_q, drn_d;
  logic [47:0]                res_q, res_d;
  logic [OPM_SKEW-1:0][7:0]   opm_q, opm_d;
  logic                       rst_sync_q, rst_sync_d;

  logic                       prod_slot;
  logic [7:0]                 slot_opm;

  // ---------------------------------------------------------------------
  // Next-state and slot decode
  // ---------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    drn_d      = drn_q;
    res_d      = res_q;
    rst_sync_d = 1'b0;
    prod_slot  = 1'b0;
    slot_opm   = OPM_HOLD;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          len_d = bus.cmd_len;
          cnt_d = '0;
          drn_d = '0;
          if (bus.cmd_len == '0) begin
            // Empty command: nothing enters the slice, answer is zero.
            res_d   = '0;
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        if (bus.s_valid) begin
          prod_slot = 1'b1;
          // The first product of a command overwrites P so no stale sum leaks in.
          slot_opm  = (cnt_q == '0) ? OPM_FIRST : OPM_ACC;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == len_q - 1'b1) begin
            drn_d   = '0;
            state_d = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        // Hold slots while the last product walks through A1/M/P. On the
        // final drain cycle dsp_p already carries the complete sum.
        if (drn_q == DRN_W'(PIPE_LAT - 1)) begin
          res_d   = bus.dsp_p;
          state_d = S_DONE;
        end else begin
          drn_d = drn_q + 1'b1;
        end
      end

      S_DONE: begin
        if (bus.res_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Opmode delay line: stage 0 takes this cycle's slot, the last stage
    // reaches the slice OPM_SKEW cycles later, in step with the M register.
    opm_d[0] = slot_opm;
    for (int i = 1; i < OPM_SKEW; i++) begin
      opm_d[i] = opm_q[i-1];
    end
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge RSTD) begin
    if (RSTD) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      drn_q      <= '0;
      res_q      <= '0;
      opm_q      <= {OPM_SKEW{OPM_HOLD}};
      rst_sync_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      drn_q      <= drn_d;
      res_q      <= res_d;
      opm_q      <= opm_d;
      rst_sync_q <= rst_sync_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  // cmd_ready is masked by RSTD so every handshake output reads 0 in reset.
  assign bus.cmd_ready  = (state_q == S_IDLE) && !RSTD;
  assign bus.s_ready    = (state_q == S_RUN);
  assign bus.res_valid  = (state_q == S_DONE);
  assign bus.res_data   = res_q;
  assign bus.busy       = (state_q != S_IDLE);

  // Hold slots present zero operands so the slice multiplies 0*0.
  assign bus.dsp_a      = prod_slot ? bus.s_a : 18'd0;
  assign bus.dsp_b      = prod_slot ? bus.s_b : 18'd0;
  assign bus.dsp_opmode = opm_q[OPM_SKEW-1];

  // Asserts with RSTD, releases on the first clk edge after RSTD falls, so
  // the slice's synchronous resets see at least one edge after release.
  assign bus.dsp_rst    = rst_sync_q;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
`timescale 1ns/1ps
module tb_dsp_mac_sequencer;

  localparam int LEN_W    = 8;
  localparam int PIPE_LAT = 3;
  localparam int DEPTH    = 4096;

  logic clk;
  logic RSTD;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dsp_mac_sequencer_if #(.LEN_W(LEN_W)) bus ();

  dsp_mac_sequencer #(
    .LEN_W   (LEN_W),
    .OPM_SKEW(1),
    .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk (clk),
    .RSTD(RSTD),
    .bus (bus)
  );

  // ---------------------------------------------------------------------
  // Check bookkeeping
  // ---------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  // ---------------------------------------------------------------------
  // DSP48A1 slice: A1/B1 -> M -> P, opmode registered alongside M
  // ---------------------------------------------------------------------
  logic [17:0] sl_a1, sl_b1;
  logic [35:0] sl_m;
  logic [47:0] sl_p;
  logic [7:0]  sl_opm;
  logic [47:0] sl_x, sl_z;

  always_comb begin
    sl_x = (sl_opm[1:0] == 2'b01) ? {12'd0, sl_m} : 48'd0;
    sl_z = (sl_opm[3:2] == 2'b10) ? sl_p : 48'd0;
  end

  always @(posedge clk) begin
    if (bus.dsp_rst) begin
      sl_a1  <= '0;
      sl_b1  <= '0;
      sl_m   <= '0;
      sl_p   <= '0;
      sl_opm <= '0;
    end else begin
      sl_a1  <= bus.dsp_a;
      sl_b1  <= bus.dsp_b;
      sl_m   <= 36'(sl_a1) * 36'(sl_b1);
      sl_opm <= bus.dsp_opmode;
      sl_p   <= sl_x + sl_z;
    end
  end

  assign bus.dsp_p = sl_p;

  // ---------------------------------------------------------------------
  // Shared stimulus state
  // ---------------------------------------------------------------------
  logic [17:0] op_a [DEPTH];
  logic [17:0] op_b [DEPTH];
  int          wr_ptr        = 0;
  int          rd_ptr        = 0;
  bit          flush         = 1'b0;
  int          gap_fixed     = 0;    // -1 selects random gaps up to gap_max
  int          gap_max       = 0;
  int          res_stall_cfg = 0;
  bit          rnd_ready     = 1'b0;
  bit          chk_en        = 1'b0;
  int          n_res         = 0;
  logic [47:0] last_res      = '0;

  // Operand source: walks the op arrays, optional idle gaps after each take.
  initial begin : feeder
    bit took;
    int gap;
    gap = 0;
    bus.s_valid = 1'b0;
    bus.s_a     = '0;
    bus.s_b     = '0;
    forever begin
      @(negedge clk);
      took = bus.s_valid && bus.s_ready;
      @(posedge clk);
      #1;
      if (flush) begin
        rd_ptr = wr_ptr;
        gap    = 0;
      end else if (took) begin
        rd_ptr++;
        gap = (gap_fixed >= 0) ? gap_fixed : int'($urandom_range(0, gap_max));
      end else if (gap > 0) begin
        gap--;
      end
      if (!flush && rd_ptr != wr_ptr && gap == 0) begin
        bus.s_valid = 1'b1;
        bus.s_a     = op_a[rd_ptr];
        bus.s_b     = op_b[rd_ptr];
      end else begin
        bus.s_valid = 1'b0;
        bus.s_a     = 18'($urandom);
        bus.s_b     = 18'($urandom);
      end
    end
  end

  // Result sink: optional fixed stall when a result appears, else ready.
  initial begin : consumer
    int stall;
    bit rv_prev;
    stall = 0;
    rv_prev = 1'b0;
    bus.res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.res_valid && !rv_prev) stall = res_stall_cfg;
      if (stall > 0) begin
        bus.res_ready = 1'b0;
        stall--;
      end else begin
        bus.res_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      rv_prev = bus.res_valid;
    end
  end

  // ---------------------------------------------------------------------
  // Scoreboard: transaction-level expectations, checked every cycle
  // ---------------------------------------------------------------------
  initial begin : scoreboard
    bit          inflight, first, rise_known, prev_rv, hs_c, hs_s, hs_r;
    int          rem;
    longint      cyc, rise_cyc;
    logic [47:0] exp_sum, prev_rd;
    logic [7:0]  exp_opm;
    cyc = 0;
    rise_cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!chk_en) begin
        inflight   = 1'b0;
        first      = 1'b0;
        rise_known = 1'b0;
        prev_rv    = 1'b0;
        rem        = 0;
        exp_sum    = '0;
        prev_rd    = '0;
        exp_opm    = 8'h08;
      end else begin
        hs_c = bus.cmd_valid && bus.cmd_ready;
        hs_s = bus.s_valid && bus.s_ready;
        hs_r = bus.res_valid && bus.res_ready;

        check("cmd_ready", bus.cmd_ready, !inflight);
        check("busy", bus.busy, inflight);
        check("s_ready", bus.s_ready, rem > 0);
        check("res_valid", bus.res_valid, inflight && rise_known && (cyc >= rise_cyc));
        check("dsp_a", bus.dsp_a, hs_s ? bus.s_a : 18'd0);
        check("dsp_b", bus.dsp_b, hs_s ? bus.s_b : 18'd0);
        check("dsp_opmode", bus.dsp_opmode, exp_opm);
        check("dsp_rst", bus.dsp_rst, 1'b0);
        if (bus.res_valid && prev_rv) check("res_hold", bus.res_data, prev_rd);
        if (hs_r) begin
          check("res_sum", bus.res_data, exp_sum);
          last_res = bus.res_data;
          n_res++;
        end

        // Opmode seen next cycle describes this cycle's slot.
        exp_opm = hs_s ? (first ? 8'h01 : 8'h09) : 8'h08;
        if (hs_c) begin
          inflight   = 1'b1;
          rem        = int'(bus.cmd_len);
          exp_sum    = '0;
          first      = 1'b1;
          rise_known = (rem == 0);
          rise_cyc   = cyc + 1;
        end
        if (hs_s) begin
          exp_sum = exp_sum + 48'(bus.s_a) * 48'(bus.s_b);
          first   = 1'b0;
          rem--;
          if (rem == 0) begin
            rise_known = 1'b1;
            rise_cyc   = cyc + PIPE_LAT + 1;
          end
        end
        if (hs_r) begin
          inflight   = 1'b0;
          rise_known = 1'b0;
        end
        prev_rv = bus.res_valid;
        prev_rd = bus.res_data;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------
  task automatic push_op(input logic [17:0] a, input logic [17:0] b);
    op_a[wr_ptr] = a;
    op_b[wr_ptr] = b;
    wr_ptr++;
  endtask

  // Raise a command and return once it has been accepted.
  task automatic issue(input int n);
    bit ok;
    ok = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = LEN_W'(n);
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("cmd_accept");
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_len   = LEN_W'($urandom);
  endtask

  task automatic wait_results(input int target, input string name);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 5000; t++) begin
      @(negedge clk);
      #1;
      if (n_res >= target) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout(name);
  endtask

  task automatic expect_result(input int target, input string name, input logic [47:0] lit);
    wait_results(target, name);
    check(name, last_res, lit);
  endtask

  // ---------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------
  initial begin : stim
    int n;
    logic [17:0] a, b;
    RSTD          = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_len   = '0;

    // Reset values while RSTD is held.
    repeat (3) @(posedge clk);
    #1;
    check("rst cmd_ready", bus.cmd_ready, 1'b0);
    check("rst s_ready", bus.s_ready, 1'b0);
    check("rst res_valid", bus.res_valid, 1'b0);
    check("rst busy", bus.busy, 1'b0);
    check("rst res_data", bus.res_data, 48'd0);
    check("rst dsp_a", bus.dsp_a, 18'd0);
    check("rst dsp_opmode", bus.dsp_opmode, 8'h08);
    check("rst dsp_rst", bus.dsp_rst, 1'b1);
    RSTD = 1'b0;
    #1;
    check("rst dsp_rst after release", bus.dsp_rst, 1'b1);
    @(posedge clk);
    #1;
    check("rst dsp_rst cleared", bus.dsp_rst, 1'b0);
    check("rst cmd_ready idle", bus.cmd_ready, 1'b1);
    chk_en = 1'b1;

    // T1: single product.
    gap_fixed = 0;
    push_op(18'd3, 18'd5);
    issue(1);
    expect_result(1, "T1 sum", 48'd15);

    // T2: back-to-back 1+4+9+16.
    for (int i = 1; i <= 4; i++) push_op(18'(i), 18'(i));
    issue(4);
    expect_result(2, "T2 sum", 48'd30);

    // T3: 100+40+7 with two idle cycles between operands.
    gap_fixed = 2;
    push_op(18'd10, 18'd10);
    push_op(18'd20, 18'd2);
    push_op(18'd7, 18'd1);
    issue(3);
    expect_result(3, "T3 sum", 48'd147);

    // T4: empty command.
    gap_fixed = 0;
    issue(0);
    expect_result(4, "T4 sum", 48'd0);

    // T5: 2*(2^18-1)^2 with the result held off for 5 cycles.
    res_stall_cfg = 5;
    push_op(18'h3FFFF, 18'h3FFFF);
    push_op(18'h3FFFF, 18'h3FFFF);
    issue(2);
    expect_result(5, "T5 sum", 48'h1F_FFF0_0002);
    res_stall_cfg = 0;

    // T6: reset in the middle of a 4-product run.
    gap_fixed = 3;
    push_op(18'd5, 18'd5);
    push_op(18'd6, 18'd6);
    push_op(18'd7, 18'd7);
    push_op(18'd8, 18'd8);
    issue(4);
    repeat (3) @(posedge clk);
    #1;
    check("T6 busy before reset", bus.busy, 1'b1);
    chk_en = 1'b0;
    flush  = 1'b1;
    RSTD   = 1'b1;
    #1;
    check("T6 busy in reset", bus.busy, 1'b0);
    check("T6 dsp_rst in reset", bus.dsp_rst, 1'b1);
    check("T6 s_ready in reset", bus.s_ready, 1'b0);
    check("T6 cmd_ready in reset", bus.cmd_ready, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    RSTD  = 1'b0;
    flush = 1'b0;
    #1;
    check("T6 dsp_rst after release", bus.dsp_rst, 1'b1);
    @(posedge clk);
    #1;
    check("T6 dsp_rst cleared", bus.dsp_rst, 1'b0);
    chk_en = 1'b1;
    gap_fixed = 0;
    push_op(18'd2, 18'd3);
    issue(1);
    expect_result(6, "T6 sum after reset", 48'd6);

    // Random commands, gaps and result stalls; next command is raised while
    // the previous one is still in flight.
    gap_fixed = -1;
    gap_max   = 2;
    rnd_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      n = int'($urandom_range(0, 10));
      for (int j = 0; j < n; j++) begin
        a = ($urandom_range(0, 7) == 0) ? 18'h3FFFF : 18'($urandom);
        b = ($urandom_range(0, 7) == 0) ? 18'h3FFFF : 18'($urandom);
        push_op(a, b);
      end
      issue(n);
    end
    wait_results(46, "random drain");

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
